// File: rtl/scs8hd_bist2_chk.sv
// BIST driver/checker for 2-input combinational cells: Gray-code stimulus, settle, sample, compare.
// Optional response signature register and SIG port when SC_BIST_MISR_EN is defined.
module scs8hd_bist2_chk #(
    parameter logic [3:0] EXP_TT     = 4'b0001,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned LOOPS      = 4,
    parameter int unsigned ERR_W      = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             STOP,
    output logic             A_O,
    output logic             B_O,
    input  logic             Y_I,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic [3:0]       FAIL_VEC
`ifdef SC_BIST_MISR_EN
    ,
    output logic [15:0]      SIG
`endif
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);
    localparam logic [7:0] LOOP_LD   = 8'(LOOPS - 1);

    typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         vec_q, vec_d;
    logic [7:0]         loop_q, loop_d;
    logic [3:0]         settle_q, settle_d;
    logic               a_q, a_d, b_q, b_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [3:0]         fail_q, fail_d;
    logic               busy, start_go, abort, mismatch;
    logic [1:0]         vec_gray;
`ifdef SC_BIST_MISR_EN
    logic [15:0]        sig_q, sig_d;
`endif

    assign vec_gray = {vec_q[1], vec_q[1] ^ vec_q[0]};
    assign start_go = (state_q == S_IDLE || state_q == S_DONE) && START && !STOP;
    assign abort    = busy && STOP;
    // Case equality so an X/Z response counts as a mismatch in simulation.
    assign mismatch = !(Y_I === EXP_TT[{a_q, b_q}]);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start_go) state_d = S_DRIVE;
            S_DRIVE:        state_d = S_SETTLE;
            S_SETTLE:       if (settle_q == 4'd0) state_d = S_SAMPLE;
            S_SAMPLE:       state_d = (vec_q == 2'd3 && loop_q == 8'd0) ? S_DONE : S_DRIVE;
            default:        state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    always_comb begin
        BUSY     = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_SAMPLE);
        DONE     = (state_q == S_DONE);
        PASS     = (state_q == S_DONE) && (err_q == '0);
        busy     = BUSY;
        A_O      = a_q;
        B_O      = b_q;
        ERR_CNT  = err_q;
        FAIL_VEC = fail_q;
`ifdef SC_BIST_MISR_EN
        SIG      = sig_q;
`endif
    end

    always_comb begin
        vec_d    = vec_q;
        loop_d   = loop_q;
        settle_d = settle_q;
        a_d      = a_q;
        b_d      = b_q;
        err_d    = err_q;
        fail_d   = fail_q;
`ifdef SC_BIST_MISR_EN
        sig_d    = sig_q;
`endif
        if (start_go) begin
            vec_d  = 2'd0;
            loop_d = LOOP_LD;
            err_d  = '0;
            fail_d = 4'd0;
`ifdef SC_BIST_MISR_EN
            sig_d  = 16'hFFFF;
`endif
        end
        if (abort) begin
            a_d = 1'b0;
            b_d = 1'b0;
        end else begin
            case (state_q)
                S_DRIVE: begin
                    a_d      = vec_gray[1];
                    b_d      = vec_gray[0];
                    settle_d = SETTLE_LD;
                end
                S_SETTLE: if (settle_q != 4'd0) settle_d = settle_q - 4'd1;
                S_SAMPLE: begin
                    if (mismatch) begin
                        if (err_q != {ERR_W{1'b1}}) err_d = err_q + 1'b1;
                        fail_d[{a_q, b_q}] = 1'b1;
                    end
`ifdef SC_BIST_MISR_EN
                    sig_d = {sig_q[14:0], 1'b0} ^ ((sig_q[15] ^ Y_I) ? 16'h1021 : 16'h0000);
`endif
                    vec_d = vec_q + 2'd1;
                    if (vec_q == 2'd3) begin
                        if (loop_q == 8'd0) begin
                            a_d = 1'b0;
                            b_d = 1'b0;
                        end else begin
                            loop_d = loop_q - 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            vec_q    <= 2'd0;
            loop_q   <= 8'd0;
            settle_q <= 4'd0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            err_q    <= '0;
            fail_q   <= 4'd0;
`ifdef SC_BIST_MISR_EN
            sig_q    <= 16'hFFFF;
`endif
        end else begin
            vec_q    <= vec_d;
            loop_q   <= loop_d;
            settle_q <= settle_d;
            a_q      <= a_d;
            b_q      <= b_d;
            err_q    <= err_d;
            fail_q   <= fail_d;
`ifdef SC_BIST_MISR_EN
            sig_q    <= sig_d;
`endif
        end
    end

endmodule
